// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, pipeline-control FSM states and the
// nine-bit latch control bundle with its canned output patterns.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    REDIR = 2'd2,
    HALT  = 2'd3
  } pctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
    logic memwb_flush;
  } pctrl_ctl_t;

  // Flush overrides enable at the latch, so enables left high under a flush are harmless.
  localparam pctrl_ctl_t CTL_RUN        = 9'b1_1_0_1_0_1_0_1_0;
  localparam pctrl_ctl_t CTL_RESET      = 9'b0_0_1_0_1_0_1_0_1;
  localparam pctrl_ctl_t CTL_IDLE       = 9'b0_0_0_0_0_0_0_0_0;
  localparam pctrl_ctl_t CTL_DMEM       = 9'b0_0_0_0_0_0_0_0_1;
  localparam pctrl_ctl_t CTL_LOAD_USE   = 9'b0_0_0_1_1_1_0_1_0;
  localparam pctrl_ctl_t CTL_BR_HIT     = 9'b1_1_1_1_1_1_0_1_0;
  localparam pctrl_ctl_t CTL_BR_MISS    = 9'b1_0_0_1_1_1_0_1_0;
  localparam pctrl_ctl_t CTL_REDIR_WAIT = 9'b0_0_0_1_1_1_0_1_0;
  localparam pctrl_ctl_t CTL_REDIR_DONE = 9'b0_1_1_1_1_1_0_1_0;
  localparam pctrl_ctl_t CTL_IMISS      = 9'b0_1_1_1_0_1_0_1_0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the ID instruction.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_dREN,
  input  regbits_t ex_Rt,
  input  regbits_t id_Rs,
  input  regbits_t id_Rt,
  output logic     load_use
);

  assign load_use = ex_dREN && (ex_Rt != '0) && ((ex_Rt == id_Rs) || (ex_Rt == id_Rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller for a five-stage CPU.
// Optional performance counters are built when PIPE_PERF_EN is defined.
//
// state | meaning
// RUN   | normal issue; hazards resolved combinationally
// DWAIT | data access outstanding, whole pipe frozen
// REDIR | PC redirected while a wrong-path fetch is still outstanding
// HALT  | processor halted until reset
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_dREN,
  input  regbits_t         ex_Rt,
  input  regbits_t         id_Rs,
  input  regbits_t         id_Rt,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             mem_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halt
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  pctrl_state_t state, state_next;
  pctrl_ctl_t   ctl;
  logic         load_use;
  logic         redirect;
  logic         dmem_wait;

  hazard_detect u_hazard_detect (
    .ex_dREN  (ex_dREN),
    .ex_Rt    (ex_Rt),
    .id_Rs    (id_Rs),
    .id_Rt    (id_Rt),
    .load_use (load_use)
  );

  assign redirect  = ex_branch_taken | ex_jump;
  // Once waiting, only dhit releases the freeze; the request itself is held in EX/MEM.
  assign dmem_wait = (state == DWAIT) ? ~dhit : ((mem_dREN | mem_dWEN) & ~dhit);

  always_comb begin
    ctl        = CTL_RUN;
    state_next = state;
    if (RST) begin
      ctl        = CTL_RESET;
      state_next = RUN;
    end else begin
      case (state)
        HALT: ctl = CTL_IDLE;
        REDIR: begin
          if (mem_halt) begin
            ctl        = CTL_IDLE;
            state_next = HALT;
          end else if (dmem_wait) begin
            ctl = CTL_DMEM;
          end else if (ihit) begin
            // PC already holds the target; drop the stale fetch and do not advance.
            ctl        = CTL_REDIR_DONE;
            state_next = RUN;
          end else begin
            ctl = CTL_REDIR_WAIT;
          end
        end
        default: begin
          state_next = RUN;
          if (mem_halt) begin
            ctl        = CTL_IDLE;
            state_next = HALT;
          end else if (dmem_wait) begin
            ctl        = CTL_DMEM;
            state_next = DWAIT;
          end else if (load_use) begin
            ctl = CTL_LOAD_USE;
          end else if (redirect && ihit) begin
            ctl = CTL_BR_HIT;
          end else if (redirect) begin
            ctl        = CTL_BR_MISS;
            state_next = REDIR;
          end else if (!ihit) begin
            ctl = CTL_IMISS;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= RUN;
    else     state <= state_next;
  end

  assign pc_en       = ctl.pc_en;
  assign ifid_en     = ctl.ifid_en;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_en     = ctl.idex_en;
  assign idex_flush  = ctl.idex_flush;
  assign exmem_en    = ctl.exmem_en;
  assign exmem_flush = ctl.exmem_flush;
  assign memwb_en    = ctl.memwb_en;
  assign memwb_flush = ctl.memwb_flush;
  assign halt        = (state == HALT);

`ifdef PIPE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  logic any_flush;

  assign any_flush = ctl.ifid_flush | ctl.idex_flush | ctl.exmem_flush | ctl.memwb_flush;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state != HALT) && !ctl.pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (any_flush && (flush_cnt != '1))                      flush_cnt <= flush_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; counter checks are built
// only when PIPE_PERF_EN is defined.
module tb_pipeline_ctrl;
  localparam int CNT_W = 32;

  // Bit order: pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, memwb_fl
  localparam logic [8:0] RUN_V        = 9'b110101010;
  localparam logic [8:0] RST_V        = 9'b001010101;
  localparam logic [8:0] HALT_V       = 9'b000000000;
  localparam logic [8:0] DMEM_V       = 9'b000000001;
  localparam logic [8:0] LU_V         = 9'b000111010;
  localparam logic [8:0] BR_HIT_V     = 9'b111111010;
  localparam logic [8:0] BR_MISS_V    = 9'b100111010;
  localparam logic [8:0] REDIR_WAIT_V = 9'b000111010;
  localparam logic [8:0] REDIR_DONE_V = 9'b011111010;
  localparam logic [8:0] IMISS_V      = 9'b011101010;

  logic CLK = 1'b0;
  logic RST, ihit, dhit, mem_dREN, mem_dWEN, ex_dREN;
  logic [4:0] ex_Rt, id_Rs, id_Rt;
  logic ex_branch_taken, ex_jump, mem_halt;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN), .ex_Rt(ex_Rt),
    .id_Rs(id_Rs), .id_Rt(id_Rt), .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .mem_halt(mem_halt), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_en(memwb_en), .memwb_flush(memwb_flush),
    .halt(halt)
`ifdef PIPE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  wire [8:0] obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                    exmem_en, exmem_flush, memwb_en, memwb_flush};

  task automatic idle();
    ihit = 1'b1; dhit = 1'b1; mem_dREN = 1'b0; mem_dWEN = 1'b0; ex_dREN = 1'b0;
    ex_Rt = 5'd0; id_Rs = 5'd1; id_Rt = 5'd2;
    ex_branch_taken = 1'b0; ex_jump = 1'b0; mem_halt = 1'b0;
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [8:0] exp, input logic exp_halt);
    #1;
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s ctl: got %b want %b", tag, obs, exp);
    total++;
    assert (halt === exp_halt) passed++;
    else $error("FAIL %s halt: got %b want %b", tag, halt, exp_halt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    RST = 1'b1;
    cyc();
    chk("reset", RST_V, 1'b0);
    cyc();
    RST = 1'b0;
    chk("run", RUN_V, 1'b0);
    cyc();

    // load-use via Rs, via Rt, and the r0 exemption
    ex_dREN = 1'b1; ex_Rt = 5'd5; id_Rs = 5'd5;
    chk("lu_rs", LU_V, 1'b0);
    cyc();
    idle();
    chk("lu_after", RUN_V, 1'b0);
    cyc();
    ex_dREN = 1'b1; ex_Rt = 5'd7; id_Rt = 5'd7;
    chk("lu_rt", LU_V, 1'b0);
    cyc();
    idle(); ex_dREN = 1'b1; ex_Rt = 5'd0; id_Rs = 5'd0;
    chk("lu_r0", RUN_V, 1'b0);
    cyc();
    idle();

    // data miss for three cycles, then hit
    mem_dREN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("dmiss", DMEM_V, 1'b0);
      cyc();
    end
    dhit = 1'b1;
    chk("dmiss_hit", RUN_V, 1'b0);
    cyc();
    idle();
    mem_dWEN = 1'b1; dhit = 1'b0;
    chk("dwr_miss", DMEM_V, 1'b0);
    cyc();
    dhit = 1'b1;
    chk("dwr_hit", RUN_V, 1'b0);
    cyc();
    idle();

    // redirect deferred behind a data miss
    mem_dREN = 1'b1; dhit = 1'b0; ex_branch_taken = 1'b1;
    chk("defer_wait", DMEM_V, 1'b0);
    cyc();
    dhit = 1'b1;
    chk("defer_apply", BR_HIT_V, 1'b0);
    cyc();
    idle();

    ex_jump = 1'b1;
    chk("jump_hit", BR_HIT_V, 1'b0);
    cyc();
    idle();

    // branch during an instruction miss
    ex_branch_taken = 1'b1; ihit = 1'b0;
    chk("br_imiss", BR_MISS_V, 1'b0);
    cyc();
    ex_branch_taken = 1'b0;
    chk("redir_w1", REDIR_WAIT_V, 1'b0);
    cyc();
    chk("redir_w2", REDIR_WAIT_V, 1'b0);
    cyc();
    ihit = 1'b1;
    chk("redir_done", REDIR_DONE_V, 1'b0);
    cyc();
    chk("redir_run", RUN_V, 1'b0);
    cyc();

    ihit = 1'b0;
    chk("imiss", IMISS_V, 1'b0);
    cyc();
    idle();

    ex_dREN = 1'b1; ex_Rt = 5'd3; id_Rs = 5'd3; ex_branch_taken = 1'b1;
    chk("lu_over_br", LU_V, 1'b0);
    cyc();
    idle();

    // halt beats data miss and load-use, then holds under random inputs
    mem_halt = 1'b1; mem_dREN = 1'b1; dhit = 1'b0;
    ex_dREN = 1'b1; ex_Rt = 5'd4; id_Rs = 5'd4;
    chk("halt_prio", HALT_V, 1'b0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      {ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_branch_taken, ex_jump, mem_halt} = 8'($urandom);
      ex_Rt = 5'($urandom); id_Rs = 5'($urandom); id_Rt = 5'($urandom);
      chk("halt_hold", HALT_V, 1'b1);
      cyc();
    end
    RST = 1'b1;
    chk("halt_rst", RST_V, 1'b1);
    cyc();
    RST = 1'b0;
    idle();
    chk("post_rst", RUN_V, 1'b0);
    cyc();

`ifdef PIPE_PERF_EN
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    ihit = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    ihit = 1'b1;
    #1;
    total++;
    assert (stall_cnt === 32'd10) passed++;
    else $error("FAIL stall_cnt: got %0d want %0d", stall_cnt, 10);
    total++;
    assert (flush_cnt === 32'd10) passed++;
    else $error("FAIL flush_cnt: got %0d want %0d", flush_cnt, 10);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
